// File: rtl/clk_pkg.sv
// Shared BCD helpers for the clock datapath: digit width, binary-to-BCD
// conversion for elaboration-time constants and per-digit validity check.
package clk_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned VEC_W      = BCD_W * MAX_DIGITS;
  // One spare digit so that 10^MAX_DIGITS is representable.
  localparam int unsigned EXT_W      = BCD_W * (MAX_DIGITS + 1);

  function automatic logic [EXT_W-1:0] to_bcd(input int unsigned v);
    logic [EXT_W-1:0] r;
    int unsigned      t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(MAX_DIGITS + 1); i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [VEC_W-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (vec[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_modulo_counter_digit.sv
// Single decade cell: clear, load, forced wrap value, or step with
// decimal carry/borrow in and out.
module bcd_digit
  import clk_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_digit,
  input  logic             i_step,
  input  logic             i_inc,
  input  logic             i_wrap,
  input  logic [BCD_W-1:0] i_wrap_val,
  output logic [BCD_W-1:0] o_d,
  output logic             o_cout
);

  logic [BCD_W-1:0] d_q;
  logic [BCD_W-1:0] d_next;

  always_comb begin
    d_next = d_q;
    if (i_clr) begin
      d_next = '0;
    end else if (i_load) begin
      d_next = i_load_digit;
    end else if (i_wrap) begin
      d_next = i_wrap_val;
    end else if (i_step) begin
      if (i_inc) d_next = (d_q == 4'd9) ? 4'd0 : d_q + 4'd1;
      else       d_next = (d_q == 4'd0) ? 4'd9 : d_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) d_q <= '0;
    else            d_q <= d_next;
  end

  assign o_d    = d_q;
  assign o_cout = i_step & (i_inc ? (d_q == 4'd9) : (d_q == 4'd0));

endmodule

// File: rtl/bcd_modulo_counter.sv
// Multi-digit BCD up/down counter with arbitrary modulus, load validation,
// combinational cascade carry and registered roll / load-error pulses.
module bcd_modulo_counter
  import clk_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clr,
  input  logic                  i_ena,
  input  logic                  i_inc,
  input  logic                  i_load,
  input  logic [BCD_W*DIGITS-1:0] i_load_val,
  output logic [BCD_W*DIGITS-1:0] o_q,
  output logic                  o_carry,
  output logic                  o_roll,
  output logic                  o_load_err
);

  localparam int unsigned      W        = BCD_W * DIGITS;
  localparam logic [EXT_W-1:0] TERM_EXT = to_bcd(MODULUS - 1);
  localparam logic [EXT_W-1:0] MOD_EXT  = to_bcd(MODULUS);
  localparam logic [W-1:0]     TERM     = TERM_EXT[W-1:0];

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_param
    $error("bcd_modulo_counter: illegal DIGITS/MODULUS combination");
  end

  logic         term;
  logic         ena_eff;
  logic         load_ok;
  logic         load_acc;
  logic         step0;
  logic         overflow;
  logic         wrap;
  logic [W-1:0] wrap_vec;

  assign term     = i_inc ? (o_q == TERM) : (o_q == '0);
  assign ena_eff  = i_ena & ~i_clr & ~i_load;
  assign load_ok  = bcd_valid(VEC_W'(i_load_val)) && (EXT_W'(i_load_val) < MOD_EXT);
  assign load_acc = i_load & load_ok;
  assign step0    = ena_eff & ~term;
  // A chain overflow is only reachable from an out-of-range count; fold it into the wrap.
  assign wrap     = ena_eff & (term | overflow);
  assign wrap_vec = i_inc ? '0 : TERM;
  assign o_carry  = i_ena & term;

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
    logic step;
    logic cout;
    if (k == 0) begin : g_lsd
      assign step = step0;
    end else begin : g_chain
      assign step = g_digit[k-1].cout;
    end
    bcd_digit u_digit (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_clr        (i_clr),
      .i_load       (load_acc),
      .i_load_digit (i_load_val[k*BCD_W +: BCD_W]),
      .i_step       (step),
      .i_inc        (i_inc),
      .i_wrap       (wrap),
      .i_wrap_val   (wrap_vec[k*BCD_W +: BCD_W]),
      .o_d          (o_q[k*BCD_W +: BCD_W]),
      .o_cout       (cout)
    );
  end

  assign overflow = g_digit[DIGITS-1].cout;

  // Wrap and rejected-load pulses; clear and load both suppress a wrap via ena_eff.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_roll     <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      o_roll     <= wrap;
      o_load_err <= i_load & ~i_clr & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Randomized and directed checks of bcd_modulo_counter against an integer
// reference model; covers the 60, 1000 and 24 moduli and a two-stage cascade.
module tb_bcd_modulo_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: DIGITS=2, MODULUS=60 (model-checked)
  logic a_clr, a_ena, a_inc, a_load, a_carry, a_roll, a_lerr;
  logic [7:0] a_lv, a_q;
  // B: DIGITS=3, MODULUS=1000
  logic b_clr, b_ena, b_inc, b_load, b_carry, b_roll, b_lerr;
  logic [11:0] b_lv, b_q;
  // C: DIGITS=2, MODULUS=24
  logic c_clr, c_ena, c_inc, c_load, c_carry, c_roll, c_lerr;
  logic [7:0] c_lv, c_q;
  // Cascade: seconds stage s feeds minutes stage m
  logic s_clr, s_ena, s_inc, s_load, s_carry, s_roll, s_lerr;
  logic m_carry, m_roll, m_lerr;
  logic [7:0] s_lv, s_q, m_lv, m_q;

  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(a_clr), .i_ena(a_ena), .i_inc(a_inc),
    .i_load(a_load), .i_load_val(a_lv), .o_q(a_q), .o_carry(a_carry),
    .o_roll(a_roll), .o_load_err(a_lerr));

  bcd_modulo_counter #(.DIGITS(3), .MODULUS(1000)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(b_clr), .i_ena(b_ena), .i_inc(b_inc),
    .i_load(b_load), .i_load_val(b_lv), .o_q(b_q), .o_carry(b_carry),
    .o_roll(b_roll), .o_load_err(b_lerr));

  bcd_modulo_counter #(.DIGITS(2), .MODULUS(24)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(c_clr), .i_ena(c_ena), .i_inc(c_inc),
    .i_load(c_load), .i_load_val(c_lv), .o_q(c_q), .o_carry(c_carry),
    .o_roll(c_roll), .o_load_err(c_lerr));

  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60)) dut_s (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(s_clr), .i_ena(s_ena), .i_inc(s_inc),
    .i_load(s_load), .i_load_val(s_lv), .o_q(s_q), .o_carry(s_carry),
    .o_roll(s_roll), .o_load_err(s_lerr));

  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60)) dut_m (
    .i_clk(clk), .i_reset_n(rst_n), .i_clr(s_clr), .i_ena(s_carry), .i_inc(s_inc),
    .i_load(s_load), .i_load_val(m_lv), .o_q(m_q), .o_carry(m_carry),
    .o_roll(m_roll), .o_load_err(m_lerr));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dec2bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Reference state of instance A as a plain integer
  int mq = 0;
  bit mroll = 0;
  bit mlerr = 0;

  task automatic cyc_a(input bit clr, input bit ena, input bit inc, input bit load,
                       input logic [7:0] lv, input string tag);
    int lo, hi;
    @(negedge clk);
    a_clr = clr; a_ena = ena; a_inc = inc; a_load = load; a_lv = lv;
    #1 check({tag, "_carry"}, 32'(a_carry), 32'(ena && (inc ? mq == 59 : mq == 0)));
    @(posedge clk);
    lo = int'(lv[3:0]);
    hi = int'(lv[7:4]);
    mroll = 0;
    mlerr = 0;
    if (clr) mq = 0;
    else if (load) begin
      if (lo <= 9 && hi <= 9 && hi * 10 + lo < 60) mq = hi * 10 + lo;
      else mlerr = 1;
    end else if (ena) begin
      if (inc) begin
        if (mq == 59) begin mq = 0; mroll = 1; end
        else mq = mq + 1;
      end else begin
        if (mq == 0) begin mq = 59; mroll = 1; end
        else mq = mq - 1;
      end
    end
    #1;
    check({tag, "_q"}, 32'(a_q), 32'(dec2bcd(mq)));
    check({tag, "_roll"}, 32'(a_roll), 32'(mroll));
    check({tag, "_lerr"}, 32'(a_lerr), 32'(mlerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    {a_clr, a_ena, a_inc, a_load} = '0; a_lv = '0;
    {b_clr, b_ena, b_inc, b_load} = '0; b_lv = '0;
    {c_clr, c_ena, c_inc, c_load} = '0; c_lv = '0;
    {s_clr, s_ena, s_inc, s_load} = '0; s_lv = '0; m_lv = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(a_q), 32'h0);
    check("rst_roll", 32'(a_roll), 32'h0);
    check("rst_lerr", 32'(a_lerr), 32'h0);
    check("rst_carry", 32'(a_carry), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Up through the terminal count
    cyc_a(0, 0, 1, 1, 8'h58, "ld58");
    cyc_a(0, 1, 1, 0, 8'h00, "up59");
    cyc_a(0, 1, 1, 0, 8'h00, "wrap_up");
    cyc_a(0, 1, 1, 0, 8'h00, "after_wrap");
    // Down through zero
    cyc_a(0, 0, 1, 1, 8'h00, "ld00");
    cyc_a(0, 1, 0, 0, 8'h00, "wrap_dn");
    cyc_a(0, 1, 0, 0, 8'h00, "dn58");
    // Load validation
    cyc_a(0, 0, 1, 1, 8'h45, "ld45");
    cyc_a(0, 0, 1, 1, 8'h60, "ld60_rej");
    cyc_a(0, 0, 1, 0, 8'h00, "lerr_clear");
    cyc_a(0, 0, 1, 1, 8'h3A, "ld3a_rej");
    cyc_a(0, 1, 1, 1, 8'h12, "ld_ena");
    cyc_a(0, 0, 1, 0, 8'h00, "hold");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit clr, ena, inc, load;
      logic [7:0] lv;
      clr  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 6) == 0);
      ena  = ($urandom_range(0, 2) != 0);
      inc  = $urandom_range(0, 1) == 1;
      lv   = ($urandom_range(0, 1) == 1) ? dec2bcd($urandom_range(0, 59))[7:0] : 8'($urandom);
      cyc_a(clr, ena, inc, load, lv, "rand");
    end

    // Asynchronous reset between edges
    cyc_a(0, 0, 1, 1, 8'h37, "ld37");
    @(negedge clk);
    a_ena = 1'b1; a_inc = 1'b0; a_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_q", 32'(a_q), 32'h0);
    check("async_roll", 32'(a_roll), 32'h0);
    check("async_carry", 32'(a_carry), 32'h1);
    mq = 0; mroll = 0; mlerr = 0;
    @(negedge clk) rst_n = 1'b1; a_ena = 1'b0;
    cyc_a(0, 0, 1, 1, 8'h25, "ld25");
    cyc_a(1, 1, 1, 1, 8'h12, "clr_all");

    // B: 3 digits, modulus 1000
    @(negedge clk); b_load = 1'b1; b_lv = 12'h999;
    @(posedge clk); #1 check("b_ld999", 32'(b_q), 32'h999);
    @(negedge clk); b_load = 1'b0; b_ena = 1'b1; b_inc = 1'b1;
    #1 check("b_carry", 32'(b_carry), 32'h1);
    @(posedge clk); #1;
    check("b_wrap_q", 32'(b_q), 32'h000);
    check("b_wrap_roll", 32'(b_roll), 32'h1);
    @(negedge clk); b_ena = 1'b0;

    // C: modulus 24
    @(negedge clk); c_load = 1'b1; c_lv = 8'h23;
    @(negedge clk); c_load = 1'b0; c_ena = 1'b1; c_inc = 1'b1;
    @(posedge clk); #1;
    check("c_wrap_q", 32'(c_q), 32'h00);
    check("c_wrap_roll", 32'(c_roll), 32'h1);
    @(negedge clk); c_ena = 1'b0; c_load = 1'b1; c_lv = 8'h19;
    @(negedge clk); c_load = 1'b0; c_ena = 1'b1;
    @(posedge clk); #1;
    check("c_19_20_q", 32'(c_q), 32'h20);
    check("c_19_20_roll", 32'(c_roll), 32'h0);
    @(negedge clk); c_ena = 1'b0; c_load = 1'b1; c_lv = 8'h24;
    @(posedge clk); #1;
    check("c_ld24_q", 32'(c_q), 32'h20);
    check("c_ld24_lerr", 32'(c_lerr), 32'h1);
    @(negedge clk); c_load = 1'b0;

    // Cascade 59:59 -> 00:00 on one edge
    @(negedge clk); s_load = 1'b1; s_lv = 8'h59; m_lv = 8'h59; s_inc = 1'b1;
    @(negedge clk); s_load = 1'b0; s_ena = 1'b1;
    #1;
    check("cas_s_carry", 32'(s_carry), 32'h1);
    check("cas_m_carry", 32'(m_carry), 32'h1);
    @(posedge clk); #1;
    check("cas_q", 32'({m_q, s_q}), 32'h0000);
    check("cas_rolls", 32'({m_roll, s_roll}), 32'h3);
    @(posedge clk); #1;
    check("cas_next_q", 32'({m_q, s_q}), 32'h0001);
    check("cas_next_rolls", 32'({m_roll, s_roll}), 32'h0);
    @(negedge clk); s_ena = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
